// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control unit: captures the instruction into an IR and sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK controls for lw, sw, add, sub and addi.
module multicycle_control_unit #(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned COUNTER_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        instr_valid,
  input  logic                        dm_ready,
  output logic                        cu_ir_load,
  output logic                        cu_pc_write_en,
  output logic [4:0]                  cu_rf_addr_a,
  output logic [4:0]                  cu_rf_addr_b,
  output logic [4:0]                  cu_rf_write_addr,
  output logic                        cu_rf_write_en,
  output logic [WORDSIZE-1:0]         cu_immediate,
  output logic                        cu_mux_0_sel,
  output logic                        cu_mux_1_sel,
  output logic                        cu_mux_2_sel,
  output logic [2:0]                  cu_alu_operation,
  output logic                        cu_dm_req,
  output logic                        cu_dm_write_en,
  output logic                        cu_illegal,
  output logic [2:0]                  cu_state,
  output logic [COUNTER_WIDTH-1:0]    cu_instret
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEM       = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  logic [2:0]                  state_q, state_d;
  logic [INSTRUCTION_SIZE-1:0] ir_q, ir_d;
  logic [COUNTER_WIDTH-1:0]    instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_lw, is_sw, is_add, is_sub, is_addi, is_legal;

  // Instruction decode, always from the IR
  always_comb begin
    opcode   = ir_q[6:0];
    funct3   = ir_q[14:12];
    funct7   = ir_q[31:25];
    is_lw    = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    is_sw    = (opcode == OP_STORE) && (funct3 == 3'b010);
    is_add   = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    is_sub   = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    is_addi  = (opcode == OP_IMM)   && (funct3 == 3'b000);
    is_legal = is_lw || is_sw || is_add || is_sub || is_addi;
  end

  always_comb begin
    cu_immediate = '0;
    if (is_lw || is_addi) begin
      cu_immediate = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:20]};
    end else if (is_sw) begin
      cu_immediate = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    end
  end

  assign cu_rf_addr_a     = ir_q[19:15];
  assign cu_rf_addr_b     = ir_q[24:20];
  assign cu_rf_write_addr = ir_q[11:7];
  assign cu_state         = state_q;
  assign cu_instret       = instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // Next state and per-phase control outputs
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    instret_d        = instret_q;
    cu_ir_load       = 1'b0;
    cu_pc_write_en   = 1'b0;
    cu_rf_write_en   = 1'b0;
    cu_mux_0_sel     = 1'b0;
    cu_mux_1_sel     = 1'b0;
    cu_mux_2_sel     = 1'b0;
    cu_alu_operation = ALU_ADD;
    cu_dm_req        = 1'b0;
    cu_dm_write_en   = 1'b0;
    cu_illegal       = 1'b0;

    // ALU controls stay stable from EXECUTE through the end of the instruction
    if ((state_q == ST_EXECUTE) || (state_q == ST_MEM) || (state_q == ST_WRITEBACK)) begin
      cu_mux_1_sel     = is_add || is_sub;
      cu_alu_operation = is_sub ? ALU_SUB : ALU_ADD;
    end

    case (state_q)
      ST_FETCH: begin
        cu_ir_load = instr_valid;
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = is_legal ? ST_EXECUTE : ST_HALT;
      end
      ST_EXECUTE: begin
        state_d = (is_lw || is_sw) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        cu_dm_req      = 1'b1;
        cu_dm_write_en = is_sw;
        if (dm_ready) begin
          if (is_sw) begin
            cu_pc_write_en = 1'b1;
            instret_d      = instret_q + COUNTER_WIDTH'(1);
            state_d        = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        cu_rf_write_en = 1'b1;
        cu_pc_write_en = 1'b1;
        cu_mux_2_sel   = is_lw;
        instret_d      = instret_q + COUNTER_WIDTH'(1);
        state_d        = ST_FETCH;
      end
      ST_HALT: begin
        cu_illegal = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against an
// instruction-level expected-trace model.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;

  localparam int K_LW   = 0;
  localparam int K_SW   = 1;
  localparam int K_ADD  = 2;
  localparam int K_SUB  = 3;
  localparam int K_ADDI = 4;
  localparam int K_ILL  = 5;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_load;
    logic       pc_we;
    logic       rf_we;
    logic       mux0;
    logic       mux1;
    logic       mux2;
    logic [2:0] alu;
    logic       dm_req;
    logic       dm_we;
    logic       illegal;
  } ctrl_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic          dm_ready;
  logic          cu_ir_load, cu_pc_write_en, cu_rf_write_en;
  logic [4:0]    cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic [63:0]   cu_immediate;
  logic          cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
  logic [2:0]    cu_alu_operation;
  logic          cu_dm_req, cu_dm_write_en, cu_illegal;
  logic [2:0]    cu_state;
  logic [CW-1:0] cu_instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_ir;
  int          model_instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .WORDSIZE(64), .INSTRUCTION_SIZE(32), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .dm_ready(dm_ready), .cu_ir_load(cu_ir_load), .cu_pc_write_en(cu_pc_write_en),
    .cu_rf_addr_a(cu_rf_addr_a), .cu_rf_addr_b(cu_rf_addr_b),
    .cu_rf_write_addr(cu_rf_write_addr), .cu_rf_write_en(cu_rf_write_en),
    .cu_immediate(cu_immediate), .cu_mux_0_sel(cu_mux_0_sel),
    .cu_mux_1_sel(cu_mux_1_sel), .cu_mux_2_sel(cu_mux_2_sel),
    .cu_alu_operation(cu_alu_operation), .cu_dm_req(cu_dm_req),
    .cu_dm_write_en(cu_dm_write_en), .cu_illegal(cu_illegal),
    .cu_state(cu_state), .cu_instret(cu_instret)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
    if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
    if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
    return K_ILL;
  endfunction

  function automatic logic [63:0] exp_imm(input logic [31:0] w);
    logic signed [11:0] i12;
    longint             v;
    int                 k;
    k = classify(w);
    if (k == K_LW || k == K_ADDI) i12 = w[31:20];
    else if (k == K_SW) i12 = {w[31:25], w[11:7]};
    else return 64'd0;
    v = i12;
    return v;
  endfunction

  function automatic ctrl_t base(input logic [2:0] st);
    ctrl_t c;
    c = '0;
    c.state = st;
    return c;
  endfunction

  function automatic ctrl_t with_alu(input ctrl_t c_in, input int k);
    ctrl_t c;
    c = c_in;
    c.mux1 = (k == K_ADD) || (k == K_SUB);
    c.alu  = (k == K_SUB) ? 3'b001 : 3'b000;
    return c;
  endfunction

  function automatic logic [31:0] make_instr(input int k);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] w;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    case (k)
      K_LW:    w = {imm, rs1, 3'b010, rd, 7'b0000011};
      K_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_ADDI:  w = {imm, rs1, 3'b000, rd, 7'b0010011};
      default: begin
        // near-miss of a legal encoding, falling back to all-ones
        w = 32'hFFFF_FFFF;
        for (int i = 0; i < 50; i++) begin
          logic [31:0] cand;
          cand = make_instr(int'($urandom_range(0, 4))) ^ (32'h1 << $urandom_range(0, 31));
          if (classify(cand) == K_ILL) begin
            w = cand;
            break;
          end
        end
      end
    endcase
    return w;
  endfunction

  // One clock: drive at negedge, compare the combinational outputs just after
  task automatic do_cycle(input logic iv, input logic [31:0] iw, input logic dr,
                          input ctrl_t e, input string tag);
    ctrl_t g;
    @(negedge clk);
    rst = 1'b0;
    instr_valid = iv;
    instruction = iw;
    dm_ready = dr;
    #1;
    g = {cu_state, cu_ir_load, cu_pc_write_en, cu_rf_write_en, cu_mux_0_sel,
         cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation, cu_dm_req, cu_dm_write_en, cu_illegal};
    check_eq({tag, "_ctrl"}, {49'd0, g}, {49'd0, e});
    check_eq({tag, "_imm"}, cu_immediate, exp_imm(model_ir));
    check_eq({tag, "_regs"}, {49'd0, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr},
             {49'd0, model_ir[19:15], model_ir[24:20], model_ir[11:7]});
    check_eq({tag, "_instret"}, {60'd0, cu_instret}, 64'(model_instret % (1 << CW)));
  endtask

  task automatic run_instr(input logic [31:0] w, input int stall, input int waits,
                           input bit abort_mem);
    int    k;
    ctrl_t e;
    k = classify(w);
    repeat (stall) do_cycle(1'b0, $urandom, 1'($urandom), base(3'd0), "fetch_idle");
    e = base(3'd0);
    e.ir_load = 1'b1;
    do_cycle(1'b1, w, 1'($urandom), e, "fetch");
    model_ir = w;
    do_cycle(1'($urandom), $urandom, 1'($urandom), base(3'd1), "decode");
    if (k == K_ILL) return;
    do_cycle(1'($urandom), $urandom, 1'($urandom), with_alu(base(3'd2), k), "execute");
    if (k == K_LW || k == K_SW) begin
      e = with_alu(base(3'd3), k);
      e.dm_req = 1'b1;
      e.dm_we  = (k == K_SW);
      repeat (waits) do_cycle(1'($urandom), $urandom, 1'b0, e, "mem_wait");
      if (abort_mem) return;
      e.pc_we = (k == K_SW);
      do_cycle(1'($urandom), $urandom, 1'b1, e, "mem_done");
      if (k == K_SW) begin
        model_instret++;
        return;
      end
    end
    e = with_alu(base(3'd4), k);
    e.rf_we = 1'b1;
    e.pc_we = 1'b1;
    e.mux2  = (k == K_LW);
    do_cycle(1'($urandom), $urandom, 1'($urandom), e, "writeback");
    model_instret++;
  endtask

  task automatic halt_cycles(input int n);
    ctrl_t e;
    e = base(3'd5);
    e.illegal = 1'b1;
    repeat (n) do_cycle(1'($urandom), $urandom, 1'($urandom), e, "halt");
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1;
      instr_valid = 1'($urandom);
      instruction = $urandom;
      dm_ready = 1'($urandom);
    end
    model_ir = 32'd0;
    model_instret = 0;
    do_cycle(1'b0, $urandom, 1'($urandom), base(3'd0), "post_reset");
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    dm_ready = 1'b0;
    model_ir = 32'd0;
    model_instret = 0;

    do_reset(2);
    repeat (3) do_cycle(1'b0, $urandom, 1'($urandom), base(3'd0), "reset_idle");

    run_instr(32'hFFD0_8293, 0, 0, 1'b0);  // addi x5, x1, -3
    run_instr(32'h4020_81B3, 1, 0, 1'b0);  // sub x3, x1, x2
    run_instr(32'h0081_2303, 0, 3, 1'b0);  // lw x6, 8(x2)
    run_instr(32'hFE71_2E23, 0, 0, 1'b0);  // sw x7, -4(x2)
    // push the narrow retired counter through its wrap
    repeat (14) run_instr(make_instr(K_ADDI), 0, 0, 1'b0);

    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
    halt_cycles(10);
    do_reset(1);

    run_instr(make_instr(K_ADD), 0, 0, 1'b0);
    run_instr(32'h0081_2303, 0, 2, 1'b1);  // reset during a MEM wait
    do_reset(1);

    for (int n = 0; n < 150; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r < 10) begin
        int k;
        k = r % 5;
        run_instr(make_instr(k), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0) && (k == K_LW || k == K_SW));
        if (dut.cu_state == 3'd3 && dut.cu_dm_req && !dm_ready && model_ir[6:0] != 7'b0110011) begin
          // an aborted memory access is left waiting; leave it via reset
        end
      end else begin
        run_instr(make_instr(K_ILL), int'($urandom_range(0, 2)), 0, 1'b0);
        halt_cycles(int'($urandom_range(1, 4)));
        do_reset(int'($urandom_range(1, 2)));
      end
      if (cu_dm_req) do_reset(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
